// File: rtl/mv_best_select.sv
// mv_best_select: best-motion-vector selector placed after the SAD engine.
// A candidate MV is paired with the SAD that returns SAD_LAT cycles later.
// The block keeps the minimum-cost candidate over a search. At the end of a
// round it either reports the winner (done) or asks for an extended round
// (go_ext). At most MAX_EXT extended rounds are allowed per search.
//
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   cand_valid/mv/last   candidate issued to the SAD engine this cycle
//   sad_in               SAD of the candidate issued SAD_LAT cycles earlier
//   ext_th, skip_ext     extension controls, sampled in DECIDE
//   mv_out, sad_out      selected vector and its SAD, held until next done
//   cand_cnt             candidates evaluated in the reported search (saturating)
//   done, go_ext         one-cycle pulses: result ready / launch extended round
//   overrun              sticky: a sample arrived in DECIDE and was dropped
module mv_best_select #(
  parameter int SAD_W      = 16,
  parameter int MV_W       = 14,
  parameter int SAD_LAT    = 3,
  parameter int MAX_EXT    = 1,
  parameter bit TIE_LATEST = 1'b0,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cand_valid,
  input  logic [MV_W-1:0]  cand_mv,
  input  logic             cand_last,
  input  logic [SAD_W-1:0] sad_in,
  input  logic [SAD_W-1:0] ext_th,
  input  logic             skip_ext,
  output logic [MV_W-1:0]  mv_out,
  output logic [SAD_W-1:0] sad_out,
  output logic [CNT_W-1:0] cand_cnt,
  output logic             done,
  output logic             go_ext,
  output logic             overrun
);

  localparam logic [0:0] ST_ACC    = 1'b0;
  localparam logic [0:0] ST_DECIDE = 1'b1;

  // Round counter is at least one bit wide so MAX_EXT=0 still elaborates;
  // with MAX_R=0 the "rounds < MAX_R" term is never true.
  localparam int             RW    = (MAX_EXT < 1) ? 1 : $clog2(MAX_EXT + 1);
  localparam logic [RW-1:0]  MAX_R = RW'(MAX_EXT);

  typedef struct packed {
    logic            last;
    logic [MV_W-1:0] mv;
  } stg_t;

  // Candidate delay line: stage SAD_LAT-1 lines up with sad_in.
  logic [SAD_LAT-1:0]       vld_pipe;
  stg_t [SAD_LAT-1:0]       dat_pipe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[0] <= cand_valid;
      dat_pipe[0] <= '{last: cand_last, mv: cand_mv};
      for (int i = 1; i < SAD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  logic            s_valid;
  logic            s_last;
  logic [MV_W-1:0] s_mv;

  assign s_valid = vld_pipe[SAD_LAT-1];
  assign s_last  = dat_pipe[SAD_LAT-1].last;
  assign s_mv    = dat_pipe[SAD_LAT-1].mv;

  logic [0:0]       state;
  logic [SAD_W-1:0] min_sad;
  logic [MV_W-1:0]  min_mv;
  logic [CNT_W-1:0] cnt;
  logic [RW-1:0]    rounds;

  logic replace;
  logic ext;

  // TIE_LATEST picks the tie rule: <= lets a later equal SAD take over.
  assign replace = TIE_LATEST ? (sad_in <= min_sad) : (sad_in < min_sad);
  // Extension needs min strictly above threshold.
  assign ext     = (min_sad > ext_th) && (rounds < MAX_R) && !skip_ext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_ACC;
      min_sad  <= '1;
      min_mv   <= '0;
      cnt      <= '0;
      rounds   <= '0;
      mv_out   <= '0;
      sad_out  <= '0;
      cand_cnt <= '0;
      done     <= 1'b0;
      go_ext   <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      done   <= 1'b0;
      go_ext <= 1'b0;
      case (state)
        ST_ACC: begin
          if (s_valid) begin
            if (replace) begin
              min_sad <= sad_in;
              min_mv  <= s_mv;
            end
            if (cnt != '1) cnt <= cnt + 1'b1;
            if (s_last) state <= ST_DECIDE;
          end
        end
        default: begin
          // Sample landing here belongs to a round issued too early; drop it.
          if (s_valid) overrun <= 1'b1;
          if (ext) begin
            go_ext <= 1'b1;
            rounds <= rounds + 1'b1;
          end else begin
            done     <= 1'b1;
            mv_out   <= min_mv;
            sad_out  <= min_sad;
            cand_cnt <= cnt;
            min_sad  <= '1;
            min_mv   <= '0;
            cnt      <= '0;
            rounds   <= '0;
          end
          state <= ST_ACC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mv_best_select.sv
// Bench for mv_best_select: two instances share stimulus, one per tie rule.
// A list-based model of the search decides the expected outcome of each round.
module tb_mv_best_select;
  localparam int SW  = 16;
  localparam int MW  = 14;
  localparam int LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          cand_valid, cand_last, skip_ext;
  logic [MW-1:0] cand_mv;
  logic [SW-1:0] sad_in, ext_th, sad_drv;
  logic [SW-1:0] sad_dl [LAT];

  // Stand-in SAD engine: returns the driven SAD LAT cycles after issue.
  always @(posedge clk) begin
    sad_dl[0] <= sad_drv;
    for (int i = 1; i < LAT; i++) sad_dl[i] <= sad_dl[i-1];
  end
  assign sad_in = sad_dl[LAT-1];

  logic [MW-1:0] mv0, mv1;
  logic [SW-1:0] so0, so1;
  logic [7:0]    cc0, cc1;
  logic          done0, done1, go0, go1, ov0, ov1;

  mv_best_select #(.SAD_LAT(LAT), .TIE_LATEST(1'b0)) dut0 (
    .clk(clk), .reset(reset), .cand_valid(cand_valid), .cand_mv(cand_mv),
    .cand_last(cand_last), .sad_in(sad_in), .ext_th(ext_th), .skip_ext(skip_ext),
    .mv_out(mv0), .sad_out(so0), .cand_cnt(cc0), .done(done0), .go_ext(go0),
    .overrun(ov0));

  mv_best_select #(.SAD_LAT(LAT), .TIE_LATEST(1'b1)) dut1 (
    .clk(clk), .reset(reset), .cand_valid(cand_valid), .cand_mv(cand_mv),
    .cand_last(cand_last), .sad_in(sad_in), .ext_th(ext_th), .skip_ext(skip_ext),
    .mv_out(mv1), .sad_out(so1), .cand_cnt(cc1), .done(done1), .go_ext(go1),
    .overrun(ov1));

  typedef struct {
    logic [MW-1:0] mv;
    logic [SW-1:0] sad;
  } cand_t;

  cand_t srch[$];   // every candidate of the current search, in issue order
  int    rounds_m;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [MW-1:0] mv, input logic [SW-1:0] sad,
                       input logic last, input bit track);
    @(negedge clk);
    cand_valid = 1'b1; cand_mv = mv; sad_drv = sad; cand_last = last;
    if (track) srch.push_back('{mv, sad});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      cand_valid = 1'b0; cand_last = 1'b0;
    end
  endtask

  // Polls for done/go_ext; k is the number of negedges waited (20 = timeout).
  task automatic wait_evt(output int k);
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      cand_valid = 1'b0; cand_last = 1'b0;
      k++;
      if (done0 | go0 | done1 | go1) break;
    end
  endtask

  // Outcome of the search so far, straight from the selection rules.
  task automatic model(output bit ext, output logic [MW-1:0] m0, output logic [MW-1:0] m1,
                       output logic [SW-1:0] ms, output logic [7:0] c);
    int first, lastx;
    ms = '1; first = -1; lastx = -1;
    foreach (srch[i]) if (srch[i].sad < ms) ms = srch[i].sad;
    foreach (srch[i]) if (srch[i].sad == ms) begin
      if (first < 0) first = i;
      lastx = i;
    end
    // With the earliest-wins rule an all-ones SAD never beats the reset minimum.
    m0 = (ms == '1 || first < 0) ? '0 : srch[first].mv;
    m1 = (lastx < 0) ? '0 : srch[lastx].mv;
    c  = (srch.size() > 255) ? 8'hFF : 8'(srch.size());
    ext = (ms > ext_th) && (rounds_m < 1) && !skip_ext;
  endtask

  task automatic check_evt(input string tag, input int k, input int exp_lat);
    bit ext;
    logic [MW-1:0] m0, m1;
    logic [SW-1:0] ms;
    logic [7:0] c;
    model(ext, m0, m1, ms, c);
    chk({tag, ".evt"}, {28'd0, done0, go0, done1, go1}, ext ? 32'h5 : 32'hA);
    if (exp_lat >= 0) chk({tag, ".lat"}, k, exp_lat);
    if (!ext) begin
      chk({tag, ".mv0"}, 32'(mv0), 32'(m0));
      chk({tag, ".mv1"}, 32'(mv1), 32'(m1));
      chk({tag, ".sad0"}, 32'(so0), 32'(ms));
      chk({tag, ".sad1"}, 32'(so1), 32'(ms));
      chk({tag, ".cnt0"}, 32'(cc0), 32'(c));
      chk({tag, ".cnt1"}, 32'(cc1), 32'(c));
      srch.delete();
      rounds_m = 0;
    end else rounds_m++;
    @(negedge clk);
    chk({tag, ".pulse"}, {28'd0, done0, go0, done1, go1}, 32'h0);
  endtask

  task automatic run_round(input string tag, input logic [MW-1:0] mvs[$],
                           input logic [SW-1:0] sads[$], input int gap_max);
    int k;
    foreach (sads[i]) begin
      if (i > 0 && gap_max > 0) idle($urandom_range(0, gap_max));
      issue(mvs[i], sads[i], i == sads.size() - 1, 1'b1);
    end
    wait_evt(k);
    check_evt(tag, k, LAT + 2);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".mv"},  {mv0, mv1} == '0 ? 32'd0 : 32'd1, 32'd0);
    chk({tag, ".sad"}, {so0, so1} == '0 ? 32'd0 : 32'd1, 32'd0);
    chk({tag, ".cnt"}, {16'd0, cc0, cc1}, 32'd0);
    chk({tag, ".flags"}, {26'd0, done0, done1, go0, go1, ov0, ov1}, 32'd0);
  endtask

  initial begin
    int k;
    bit seen;
    logic [MW-1:0] mq[$];
    logic [SW-1:0] sq[$];
    reset = 1'b1; cand_valid = 0; cand_last = 0; cand_mv = '0; sad_drv = '0;
    ext_th = 16'd2500; skip_ext = 1'b0; rounds_m = 0;
    idle(2);
    chk_reset_vals("reset");
    reset = 1'b0;
    idle(2);

    // Basic round, both tie rules; spec constants checked directly too.
    run_round("basic", '{1, 2, 3, 4}, '{900, 400, 400, 700}, 0);
    chk("basic.const0", {mv0, so0, cc0}, {14'd2, 16'd400, 8'd4});
    chk("basic.const1", {mv1, so1, cc1}, {14'd3, 16'd400, 8'd4});

    // Extension, then extended round which must finish with done.
    run_round("ext1", '{11, 12}, '{3000, 2800}, 0);
    run_round("ext2", '{13, 14}, '{2600, 2700}, 0);
    chk("ext2.const", {mv0, cc0}, {14'd13, 8'd4});

    // skip_ext suppresses extension; min == threshold does not extend.
    skip_ext = 1'b1;
    run_round("skip", '{21, 22}, '{2900, 2800}, 0);
    skip_ext = 1'b0;
    run_round("eq_th", '{31, 32, 33}, '{2600, 2500, 2700}, 1);
    chk("eq_th.const", {mv0, so0}, {14'd32, 16'd2500});

    // All-ones SAD: earliest rule keeps the reset MV, latest rule takes it.
    ext_th = 16'hFFFF;
    run_round("allones", '{41}, '{16'hFFFF}, 0);
    ext_th = 16'd2500;

    // Next round issued at T+1 collides with DECIDE and is dropped.
    issue(51, 1000, 1'b1, 1'b1);
    issue(52, 10, 1'b1, 1'b0);
    wait_evt(k);
    check_evt("ovr", k, LAT + 1);
    chk("ovr.flag", {30'd0, ov0, ov1}, 32'h3);
    seen = 0;
    repeat (8) begin @(negedge clk); seen |= done0 | go0 | done1 | go1; end
    chk("ovr.noevt", {31'd0, seen}, 32'd0);
    reset = 1'b1; idle(1); reset = 1'b0; idle(1);
    chk("ovr.clear", {30'd0, ov0, ov1}, 32'h0);

    // Next round issued at T+2 is legal and counted in the fresh search.
    issue(61, 1200, 1'b1, 1'b1);
    idle(1);
    issue(62, 1300, 1'b1, 1'b0);
    wait_evt(k);
    check_evt("t2.a", k, LAT);
    srch.push_back('{14'd62, 16'd1300});
    wait_evt(k);
    check_evt("t2.b", k, -1);
    chk("t2.const", {mv0, cc0}, {14'd62, 8'd1});
    chk("t2.ovr", {30'd0, ov0, ov1}, 32'h0);

    // Reset two cycles before s_last aborts the search silently.
    issue(71, 100, 1'b0, 1'b1);
    issue(72, 50, 1'b0, 1'b1);
    issue(73, 70, 1'b1, 1'b1);
    @(negedge clk);
    cand_valid = 1'b0; cand_last = 1'b0; reset = 1'b1;
    idle(2);
    reset = 1'b0;
    chk_reset_vals("midrst");
    srch.delete(); rounds_m = 0;
    seen = 0;
    repeat (8) begin @(negedge clk); seen |= done0 | go0 | done1 | go1; end
    chk("midrst.noevt", {31'd0, seen}, 32'd0);
    run_round("postrst", '{81, 82}, '{2100, 2050}, 0);

    // Randomized rounds, including extensions, skips and gaps.
    for (int r = 0; r < 40; r++) begin
      int n;
      n = $urandom_range(1, 6);
      mq.delete(); sq.delete();
      for (int i = 0; i < n; i++) begin
        mq.push_back(MW'($urandom));
        if ($urandom_range(0, 3) == 0) sq.push_back(SW'($urandom));
        else sq.push_back(SW'($urandom_range(2200, 3000)));
      end
      ext_th   = ($urandom_range(0, 1) == 1) ? 16'd2500 : SW'($urandom);
      skip_ext = ($urandom_range(0, 4) == 0);
      run_round("rand", mq, sq, 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mv_best_select.md
# mv_best_select

Parametrised best-motion-vector selector for the motion-estimation datapath. It sits after the SAD engine. It pairs each candidate motion vector with the SAD result that returns SAD_LAT cycles later and tracks the minimum-cost candidate across a search round. At round end it either reports the winner or requests an extended search round, up to a configurable round limit.

## Interface
Parameters:
- SAD_W, 16, SAD width in bits
- MV_W, 14, motion-vector width in bits
- SAD_LAT, 3, cycles from candidate issue to SAD valid (≥1)
- MAX_EXT, 1, maximum extended rounds per search (0 disables extension)
- TIE_LATEST, 0, 0: earliest candidate wins ties; 1: latest candidate wins ties
- CNT_W, 8, width of the candidate counter

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- cand_valid  in  1  candidate issued to SAD engine this cycle
- cand_mv  in  MV_W  candidate motion vector
- cand_last  in  1  last candidate of the current round; qualified by cand_valid
- sad_in  in  SAD_W  SAD of the candidate issued SAD_LAT cycles earlier
- ext_th  in  SAD_W  extension threshold; sampled in DECIDE
- skip_ext  in  1  suppress extension (early-termination hint); sampled in DECIDE
- mv_out  out  MV_W  selected vector; held until next done
- sad_out  out  SAD_W  SAD of the selected vector; held until next done
- cand_cnt  out  CNT_W  candidates evaluated in the reported search; saturates at all-ones
- done  out  1  one-cycle pulse: mv_out/sad_out updated
- go_ext  out  1  one-cycle pulse: launch an extended round
- overrun  out  1  sticky: a sample arrived during DECIDE and was dropped

## Operation
- Delay line: {cand_valid, cand_last, cand_mv} shifts through SAD_LAT register stages. The stage outputs s_valid, s_last and s_mv align with sad_in.
- Running minimum: min_sad resets to all-ones, min_mv to 0. On s_valid in state ACC:
  - TIE_LATEST=0: replace when sad_in < min_sad.
  - TIE_LATEST=1: replace when sad_in ≤ min_sad.
  - The comparison is unsigned, full SAD_W.
- Counter: cnt increments on every accepted sample and saturates at all-ones. A sample whose sad_in equals all-ones with TIE_LATEST=0 is counted but does not replace the minimum.
- FSM:
  - ACC: accepts samples. s_valid && s_last → DECIDE. The last sample is also applied to the minimum.
  - DECIDE, lasts one cycle: compute ext = (min_sad > ext_th) && (rounds < MAX_EXT) && !skip_ext.
    - If ext: go_ext pulses, rounds increments, min_sad/min_mv/cnt are kept, next state ACC.
    - Otherwise: done pulses, mv_out←min_mv, sad_out←min_sad, cand_cnt←cnt, then min_sad←all-ones, min_mv←0, cnt←0, rounds←0, next state ACC.
  - s_valid during DECIDE: the sample is dropped and overrun is set. overrun is cleared only by reset.
- min_sad == ext_th does not extend (strictly greater required).

## Timing
- Reset values: mv_out=0, sad_out=0, cand_cnt=0, done=0, go_ext=0, overrun=0, state=ACC, rounds=0, min_sad=all-ones, min_mv=0, delay line cleared.
- Reset mid-round discards all in-flight samples and the running state. No done or go_ext is issued for the aborted search.
- Latency: cand_last issued in cycle T → s_last in cycle T+SAD_LAT → DECIDE in T+SAD_LAT+1 → done or go_ext high in cycle T+SAD_LAT+2. Outputs are registered, with no combinational path from inputs.
- done and go_ext are mutually exclusive and exactly one cycle wide.
- Earliest legal next-round candidate issue is cycle T+2. The first sample of the next round then reaches ACC in cycle T+SAD_LAT+2 and is counted in the fresh search. Issuing at T+1 overruns.
- Back-to-back candidates every cycle are supported. Gaps in cand_valid are allowed.
- A single-candidate round (cand_valid && cand_last in the same cycle) is legal.

## Test plan
- One round, SADs 900, 400, 400, 700 with MVs 1-4, ext_th=2500, TIE_LATEST=0 → done at T+5 (SAD_LAT=3), mv_out=2, sad_out=400, cand_cnt=4.
- Same round with TIE_LATEST=1 → mv_out=3, sad_out=400.
- SADs 3000, 2800 with ext_th=2500, MAX_EXT=1 → go_ext pulse, no done. Extended round SADs 2600, 2700 → done, mv_out = MV of 2600, cand_cnt=4. A second round above threshold gives done, not go_ext.
- Round minimum 2800 with skip_ext=1 in DECIDE → done, mv_out = MV of 2800. Round minimum exactly 2500 → done, no extension.
- Next round's cand_valid issued at T+1 → overrun=1, that sample not counted. Issued at T+2 → overrun stays 0, counted in the new search.
- Assert reset two cycles before s_last → all outputs return to reset values, no done or go_ext. A fresh round afterwards reports correctly.
